// File: rtl/guess_checker.sv
// guess_checker: latches a target from the random generator, accepts player
// guesses on a synchronized active-low button, counts attempts and flags
// win/lose. Optional too-high/too-low hints are built when GUESS_HINT_EN is
// defined; otherwise high/low are tied low and only equality is checked.
module guess_checker #(
  parameter int MAX_TRIES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] target,
  input  logic       load,
  input  logic [3:0] guess,
  input  logic       submit_n,
  input  logic       enable,
  output logic       win,
  output logic       lose,
  output logic       high,
  output logic       low,
  output logic [2:0] attempts,
  output logic       armed
);

  typedef enum logic [1:0] {IDLE, ARMED, WIN, LOSE} state_t;

  localparam logic [2:0] MaxTries = 3'(MAX_TRIES);

  state_t     state_q, state_d;
  logic [3:0] target_q, target_d;
  logic [2:0] att_q, att_d;
  logic       s1_q, s2_q, s3_q;
  logic       press_evt;
  logic       accept;

  // Button synchronizer plus history flop; idle level is released (1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= submit_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // One-cycle pulse per falling edge of the synchronized button.
  assign press_evt = s3_q & ~s2_q;

  // A press counts only in ARMED, while enabled, and when load is not
  // restarting the round in the same cycle.
  assign accept = (state_q == ARMED) & press_evt & enable & ~load;

  // Next-state: load restarts the round from any state; an accepted press
  // bumps the count and resolves win/lose.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    att_d    = att_q;
    if (load) begin
      state_d  = ARMED;
      target_d = target;
      att_d    = 3'd0;
    end else if (accept) begin
      att_d = att_q + 3'd1;
      if (guess == target_q)
        state_d = WIN;
      else if (att_d == MaxTries)
        state_d = LOSE;
    end
  end

  // Round state, latched target and attempt counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= 4'd0;
      att_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      att_q    <= att_d;
    end
  end

`ifdef GUESS_HINT_EN
  logic high_q, high_d, low_q, low_d;

  // Hints track the last accepted guess; a match yields both low, and
  // a losing miss still shows its hint.
  always_comb begin
    high_d = high_q;
    low_d  = low_q;
    if (load) begin
      high_d = 1'b0;
      low_d  = 1'b0;
    end else if (accept) begin
      high_d = guess > target_q;
      low_d  = guess < target_q;
    end
  end

  // Hint registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_q <= 1'b0;
      low_q  <= 1'b0;
    end else begin
      high_q <= high_d;
      low_q  <= low_d;
    end
  end

  assign high = high_q;
  assign low  = low_q;
`else
  assign high = 1'b0;
  assign low  = 1'b0;
`endif

  assign win      = (state_q == WIN);
  assign lose     = (state_q == LOSE);
  assign armed    = (state_q == ARMED);
  assign attempts = att_q;

endmodule
